// File: rtl/hc595_chain_driver_if.sv
// Word-source and 595-pin bundle for hc595_chain_driver.
// Handshake: a word transfers on a rising clk edge where load=1 and ready=1; load while ready=0 drops the word and pulses ovf.
interface hc595_chain_driver_if #(
    parameter int DATA_W = 16
);
    logic              load;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              busy;
    logic              done;
    logic              ovf;
    logic              ds;
    logic              sh_cp;
    logic              st_cp;

    modport master (
        output load, data,
        input  ready, busy, done, ovf, ds, sh_cp, st_cp
    );

    modport slave (
        input  load, data,
        output ready, busy, done, ovf, ds, sh_cp, st_cp
    );
endinterface

// File: rtl/hc595_chain_driver.sv
// Serialises a DATA_W-bit word into a 74HC595 daisy chain, with a one-deep pending buffer
// so a new word can be queued while the current frame is still shifting.
module hc595_chain_driver #(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    hc595_chain_driver_if.slave     bus,
    output logic [2:0]              state_dbg
);
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SH_LO = 3'd1,
        ST_SH_HI = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic              ds_q, ds_d;
    logic              sh_cp_q, sh_cp_d;
    logic              st_cp_q, st_cp_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    logic              accept;
    logic              phase_end;
    logic              start;
    logic [DATA_W-1:0] start_word;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign accept    = bus.load & ready_q;
    assign phase_end = (div_q == DIV_LAST);

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        ds_d         = ds_q;
        sh_cp_d      = sh_cp_q;
        st_cp_d      = st_cp_q;
        done_d       = 1'b0;
        start        = 1'b0;
        start_word   = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    start      = 1'b1;
                    start_word = bus.data;
                end
            end
            ST_SH_LO: begin
                if (phase_end) begin
                    state_d = ST_SH_HI;
                    div_d   = '0;
                    sh_cp_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SH_HI: begin
                if (phase_end) begin
                    div_d   = '0;
                    bit_d   = bit_q + BIT_W'(1);
                    sh_cp_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_LATCH;
                        ds_d    = 1'b0;
                        st_cp_d = 1'b1;
                    end else begin
                        state_d = ST_SH_LO;
                        ds_d    = first_bit(shift_q);
                        shift_d = advance(shift_q);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (phase_end) begin
                    state_d = ST_DONE;
                    div_d   = '0;
                    st_cp_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                // A queued word wins; otherwise a word offered right now chains on without an IDLE gap.
                if (pend_valid_q) begin
                    start        = 1'b1;
                    start_word   = pend_q;
                    pend_valid_d = 1'b0;
                end else if (accept) begin
                    start      = 1'b1;
                    start_word = bus.data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && (state_q != ST_IDLE) && !(state_q == ST_DONE && !pend_valid_q)) begin
            pend_d       = bus.data;
            pend_valid_d = 1'b1;
        end

        if (start) begin
            state_d = ST_SH_LO;
            div_d   = '0;
            bit_d   = '0;
            ds_d    = first_bit(start_word);
            shift_d = advance(start_word);
        end

        ready_d = ~pend_valid_d;
        busy_d  = (state_d != ST_IDLE);
        ovf_d   = bus.load & ~ready_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            ds_q         <= 1'b0;
            sh_cp_q      <= 1'b0;
            st_cp_q      <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            ds_q         <= ds_d;
            sh_cp_q      <= sh_cp_d;
            st_cp_q      <= st_cp_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;
    assign bus.ds    = ds_q;
    assign bus.sh_cp = sh_cp_q;
    assign bus.st_cp = st_cp_q;
    assign state_dbg = state_q;
endmodule
